ram_write_arbiter: RTL and testbench

//   Shares the single write port of the data RAM (RAM_DUAL_READ_PORT) between
//   NUM_REQ requesters: the MiniAlu core, a host program/data loader and debug

---
 rtl/ram_write_arbiter_pkg.sv | 21 ++
 rtl/ram_write_arbiter_rr_pick.sv | 37 +++
 rtl/ram_write_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ram_write_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_write_arbiter_pkg.sv
// ram_write_arbiter_pkg
//   Shared definitions for the RAM write-port arbiter: FSM state encodings,
//   the conflict counter saturation value, the requester index type and a
//   modulo-N increment helper for the round-robin pointer.
package ram_write_arbiter_pkg;

  localparam int IDX_W = 3;
  typedef logic [IDX_W-1:0] idx_t;

  localparam logic [0:0] ARB_IDLE   = 1'b0;
  localparam logic [0:0] ARB_LOCKED = 1'b1;

  localparam logic [15:0] ARB_CNT_MAX = 16'hFFFF;

  // (i + 1) mod n for a requester index, n in 1..8
  function automatic idx_t wrapInc(input idx_t i, input int n);
    if (int'(i) >= n - 1) return '0;
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/ram_write_arbiter_rr_pick.sv
// ram_write_arbiter_rr_pick
//   Combinational round-robin picker: selects the first set bit of req at or
//   after ptr, wrapping around.
//   req      in   N     request vector
//   ptr      in   3     search start index (must be < N)
//   grant    out  N     one-hot grant, zero when req is zero
//   grantIdx out  3     index of the granted bit, 0 when none
module ram_write_arbiter_rr_pick
  import ram_write_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  idx_t         ptr,
  output logic [N-1:0] grant,
  output idx_t         grantIdx
);

  logic found;
  int   j;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    j        = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        grantIdx = idx_t'(j);
      end
    end
  end

endmodule

// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter
//   Shares the single RAM write port between NUM_REQ requesters using
//   round-robin arbitration, with an optional grant lock for bursts and a
//   forced release when the lock holder stays idle for LOCK_TIMEOUT cycles.
//   Clock          in   1                   posedge clock
//   Reset          in   1                   synchronous, active-high
//   iReqValid      in   NUM_REQ             per-requester write request
//   iReqLock       in   NUM_REQ             keep grant after this transfer
//   iReqAddr       in   NUM_REQ*ADDR_WIDTH  flattened, slice i = requester i
//   iReqData       in   NUM_REQ*DATA_WIDTH  flattened, slice i = requester i
//   oReqReady      out  NUM_REQ             one-hot or zero, transfer = valid & ready
//   oWriteEnable   out  1                   registered RAM write strobe
//   oWriteAddress  out  ADDR_WIDTH          registered RAM write address
//   oWriteData     out  DATA_WIDTH          registered RAM write data
//   oLockOwner     out  3                   lock holder index, 0 when unlocked
//   oLocked        out  1                   high while locked
//   oLockTimeout   out  1                   one-cycle pulse after a forced release
//   oConflictCount out  16                  saturating count of cycles with >1 valid
module ram_write_arbiter
  import ram_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            iReqValid,
  input  logic [NUM_REQ-1:0]            iReqLock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] iReqAddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] iReqData,
  output logic [NUM_REQ-1:0]            oReqReady,
  output logic                          oWriteEnable,
  output logic [ADDR_WIDTH-1:0]         oWriteAddress,
  output logic [DATA_WIDTH-1:0]         oWriteData,
  output logic [2:0]                    oLockOwner,
  output logic                          oLocked,
  output logic                          oLockTimeout,
  output logic [15:0]                   oConflictCount
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  logic [0:0]            stateQ;
  idx_t                  ptrQ;
  idx_t                  ownerQ;
  logic [TW-1:0]         toCntQ;
  logic [15:0]           conflictQ;
  logic                  wrEnQ;
  logic [ADDR_WIDTH-1:0] wrAddrQ;
  logic [DATA_WIDTH-1:0] wrDataQ;
  logic                  timeoutQ;

  logic [NUM_REQ-1:0]    ownerMask;
  logic [NUM_REQ-1:0]    pickReq;
  idx_t                  pickPtr;
  logic [NUM_REQ-1:0]    grant;
  idx_t                  gIdx;
  logic                  xfer;
  logic                  lockSel;
  logic                  ownerValid;
  logic                  toTerm;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selData;

  // While locked the picker only sees the owner, so the same picker serves
  // both states and ready can never go to a stalled requester.
  always_comb begin
    ownerMask = '0;
    for (int i = 0; i < NUM_REQ; i++) ownerMask[i] = (ownerQ == idx_t'(i));
  end

  assign pickReq = (stateQ == ARB_LOCKED) ? (iReqValid & ownerMask) : iReqValid;
  assign pickPtr = (stateQ == ARB_LOCKED) ? ownerQ : ptrQ;

  ram_write_arbiter_rr_pick #(.N(NUM_REQ)) rrPick (
    .req      (pickReq),
    .ptr      (pickPtr),
    .grant    (grant),
    .grantIdx (gIdx)
  );

  assign xfer       = |grant;
  assign lockSel    = |(grant & iReqLock);
  assign ownerValid = |(iReqValid & ownerMask);
  // Release on the idle cycle that would bring the count to LOCK_TIMEOUT,
  // so the pulse and the unlocked state appear together on the next cycle.
  assign toTerm     = (toCntQ == TW'(LOCK_TIMEOUT - 1));

  always_comb begin
    selAddr = '0;
    selData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        selAddr = iReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        selData = iReqData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateQ    <= ARB_IDLE;
      ptrQ      <= '0;
      ownerQ    <= '0;
      toCntQ    <= '0;
      conflictQ <= '0;
      wrEnQ     <= 1'b0;
      wrAddrQ   <= '0;
      wrDataQ   <= '0;
      timeoutQ  <= 1'b0;
    end else begin
      wrEnQ    <= xfer;
      timeoutQ <= 1'b0;
      if (xfer) begin
        wrAddrQ <= selAddr;
        wrDataQ <= selData;
      end

      case (stateQ)
        ARB_IDLE: begin
          if (xfer) begin
            ptrQ <= wrapInc(gIdx, NUM_REQ);
            if (lockSel) begin
              stateQ <= ARB_LOCKED;
              ownerQ <= gIdx;
              toCntQ <= '0;
            end
          end
        end
        default: begin
          if (xfer) begin
            toCntQ <= '0;
            if (!lockSel) begin
              stateQ <= ARB_IDLE;
              ptrQ   <= wrapInc(ownerQ, NUM_REQ);
              ownerQ <= '0;
            end
          end else if (!ownerValid) begin
            if (toTerm) begin
              stateQ   <= ARB_IDLE;
              ptrQ     <= wrapInc(ownerQ, NUM_REQ);
              ownerQ   <= '0;
              toCntQ   <= '0;
              timeoutQ <= 1'b1;
            end else begin
              toCntQ <= toCntQ + TW'(1);
            end
          end
        end
      endcase

      if (($countones(iReqValid) > 1) && (conflictQ != ARB_CNT_MAX))
        conflictQ <= conflictQ + 16'd1;
    end
  end

  assign oReqReady      = grant;
  assign oWriteEnable   = wrEnQ;
  assign oWriteAddress  = wrAddrQ;
  assign oWriteData     = wrDataQ;
  assign oLockOwner     = ownerQ;
  assign oLocked        = (stateQ == ARB_LOCKED);
  assign oLockTimeout   = timeoutQ;
  assign oConflictCount = conflictQ;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// tb_ram_write_arbiter
//   Table-driven bench for ram_write_arbiter with a write scoreboard.
module tb_ram_write_arbiter;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LT = 15;

  logic           Clock = 1'b0;
  logic           Reset;
  logic [NR-1:0]  iReqValid;
  logic [NR-1:0]  iReqLock;
  logic [NR*AW-1:0] iReqAddr;
  logic [NR*DW-1:0] iReqData;
  logic [NR-1:0]  oReqReady;
  logic           oWriteEnable;
  logic [AW-1:0]  oWriteAddress;
  logic [DW-1:0]  oWriteData;
  logic [2:0]     oLockOwner;
  logic           oLocked;
  logic           oLockTimeout;
  logic [15:0]    oConflictCount;

  ram_write_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .iReqValid(iReqValid), .iReqLock(iReqLock),
    .iReqAddr(iReqAddr), .iReqData(iReqData),
    .oReqReady(oReqReady),
    .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress), .oWriteData(oWriteData),
    .oLockOwner(oLockOwner), .oLocked(oLocked), .oLockTimeout(oLockTimeout),
    .oConflictCount(oConflictCount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] lock;
    logic [NR-1:0] expReady;
    logic          expLocked;
    logic [2:0]    expOwner;
    logic          expTimeout;
    string         name;
  } vec_t;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];

  logic [AW-1:0] tbAddr[NR];
  logic [DW-1:0] tbData[NR];
  logic [15:0]   expConf;
  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void addVec(input logic [NR-1:0] v, input logic [NR-1:0] l,
                                 input logic [NR-1:0] r, input logic lk,
                                 input logic [2:0] ow, input logic to, input string n);
    vec_t e;
    e.valid = v; e.lock = l; e.expReady = r; e.expLocked = lk;
    e.expOwner = ow; e.expTimeout = to; e.name = n;
    vecs.push_back(e);
  endfunction

  // One arbitration cycle: drive after negedge, check combinational ready and
  // state outputs, queue the expected write, then check it after the edge.
  task automatic step(input vec_t v);
    wr_t exp;
    wr_t got;
    int  idx;
    @(negedge Clock);
    iReqValid = v.valid;
    iReqLock  = v.lock;
    for (int i = 0; i < NR; i++) begin
      iReqAddr[i*AW +: AW] = tbAddr[i];
      iReqData[i*DW +: DW] = tbData[i];
    end
    #1;
    chk({v.name, " ready"},   32'(oReqReady),    32'(v.expReady));
    chk({v.name, " locked"},  32'(oLocked),      32'(v.expLocked));
    chk({v.name, " owner"},   32'(oLockOwner),   32'(v.expOwner));
    chk({v.name, " timeout"}, 32'(oLockTimeout), 32'(v.expTimeout));
    exp = '0;
    idx = -1;
    for (int i = 0; i < NR; i++) if (v.expReady[i]) idx = i;
    if (idx >= 0) begin
      exp.en = 1'b1; exp.a = tbAddr[idx]; exp.d = tbData[idx];
      tbAddr[idx] = tbAddr[idx] + 8'd1;
      tbData[idx] = tbData[idx] + 16'd1;
    end
    sb.push_back(exp);
    if (($countones(v.valid) > 1) && (expConf != 16'hFFFF)) expConf = expConf + 16'd1;
    @(posedge Clock);
    #1;
    if (sb.size() == 0) begin
      chk({v.name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk({v.name, " wrEn"}, 32'(oWriteEnable), 32'(got.en));
      if (got.en) begin
        chk({v.name, " wrAddr"}, 32'(oWriteAddress), 32'(got.a));
        chk({v.name, " wrData"}, 32'(oWriteData),    32'(got.d));
      end
    end
    chk({v.name, " conflict"}, 32'(oConflictCount), 32'(expConf));
  endtask

  task automatic runRange(input int lo, input int hi);
    for (int k = lo; k < hi; k++) step(vecs[k]);
  endtask

  task automatic idleStep();
    vec_t e;
    e.valid = '0; e.lock = '0; e.expReady = '0; e.expLocked = 1'b0;
    e.expOwner = '0; e.expTimeout = 1'b0; e.name = "idle";
    step(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, t3, tEnd;
    vec_t e;

    // Test 1: all valid, plain round robin
    t1 = 0;
    addVec(4'b1111, 4'b0000, 4'b0001, 1'b0, 3'd0, 1'b0, "t1 g0");
    addVec(4'b1111, 4'b0000, 4'b0010, 1'b0, 3'd0, 1'b0, "t1 g1");
    addVec(4'b1111, 4'b0000, 4'b0100, 1'b0, 3'd0, 1'b0, "t1 g2");
    addVec(4'b1111, 4'b0000, 4'b1000, 1'b0, 3'd0, 1'b0, "t1 g3");
    addVec(4'b1111, 4'b0000, 4'b0001, 1'b0, 3'd0, 1'b0, "t1 wrap");
    // Test 2: req1 burst under lock, req0/req2 stall, then req2
    t2 = vecs.size();
    addVec(4'b0111, 4'b0010, 4'b0010, 1'b0, 3'd0, 1'b0, "t2 lock");
    addVec(4'b0111, 4'b0010, 4'b0010, 1'b1, 3'd1, 1'b0, "t2 burst1");
    addVec(4'b0111, 4'b0010, 4'b0010, 1'b1, 3'd1, 1'b0, "t2 burst2");
    addVec(4'b0111, 4'b0010, 4'b0010, 1'b1, 3'd1, 1'b0, "t2 burst3");
    addVec(4'b0111, 4'b0000, 4'b0010, 1'b1, 3'd1, 1'b0, "t2 last");
    addVec(4'b0111, 4'b0000, 4'b0100, 1'b0, 3'd0, 1'b0, "t2 next");
    // Test 3: req3 locks then idles until the forced release
    t3 = vecs.size();
    addVec(4'b1000, 4'b1000, 4'b1000, 1'b0, 3'd0, 1'b0, "t3 lock");
    for (int i = 0; i < LT; i++)
      addVec(4'b0011, 4'b0000, 4'b0000, 1'b1, 3'd3, 1'b0, "t3 stall");
    addVec(4'b0011, 4'b0000, 4'b0001, 1'b0, 3'd0, 1'b1, "t3 release");
    addVec(4'b0011, 4'b0000, 4'b0010, 1'b0, 3'd0, 1'b0, "t3 after");
    tEnd = vecs.size();

    for (int i = 0; i < NR; i++) begin
      tbAddr[i] = AW'(i * 16);
      tbData[i] = 16'hA000 + DW'(i * 256);
    end
    expConf   = '0;
    Reset     = 1'b1;
    iReqValid = '0;
    iReqLock  = '0;
    iReqAddr  = '0;
    iReqData  = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset wrEn",     32'(oWriteEnable),   32'd0);
    chk("reset addr",     32'(oWriteAddress),  32'd0);
    chk("reset data",     32'(oWriteData),     32'd0);
    chk("reset locked",   32'(oLocked),        32'd0);
    chk("reset owner",    32'(oLockOwner),     32'd0);
    chk("reset timeout",  32'(oLockTimeout),   32'd0);
    chk("reset conflict", 32'(oConflictCount), 32'd0);
    chk("reset ready",    32'(oReqReady),      32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    runRange(t1, t2);
    idleStep();
    tbAddr[1] = 8'h10;
    tbData[1] = 16'hBEEF;
    runRange(t2, t3);
    idleStep();
    runRange(t3, tEnd);
    idleStep();

    // Test 4: single requester at the top address
    tbAddr[2] = 8'hFF;
    tbData[2] = 16'h1234;
    e.valid = 4'b0100; e.lock = '0; e.expReady = 4'b0100; e.expLocked = 1'b0;
    e.expOwner = '0; e.expTimeout = 1'b0; e.name = "t4 single";
    step(e);
    chk("t4 addr FF",   32'(oWriteAddress), 32'h00FF);
    chk("t4 data 1234", 32'(oWriteData),    32'h1234);

    // Test 5: reset while locked with a write in the output register
    e.valid = 4'b0001; e.lock = 4'b0001; e.expReady = 4'b0001; e.expLocked = 1'b0;
    e.expOwner = '0; e.expTimeout = 1'b0; e.name = "t5 lock";
    step(e);
    chk("t5 pre locked", 32'(oLocked),      32'd1);
    chk("t5 pre wrEn",   32'(oWriteEnable), 32'd1);
    @(negedge Clock);
    Reset     = 1'b1;
    iReqValid = '0;
    iReqLock  = '0;
    @(posedge Clock);
    #1;
    chk("t5 wrEn",     32'(oWriteEnable),   32'd0);
    chk("t5 addr",     32'(oWriteAddress),  32'd0);
    chk("t5 data",     32'(oWriteData),     32'd0);
    chk("t5 locked",   32'(oLocked),        32'd0);
    chk("t5 owner",    32'(oLockOwner),     32'd0);
    chk("t5 conflict", 32'(oConflictCount), 32'd0);
    @(negedge Clock);
    Reset   = 1'b0;
    expConf = '0;
    sb.delete();
    e.valid = 4'b1111; e.lock = '0; e.expReady = 4'b0001; e.expLocked = 1'b0;
    e.expOwner = '0; e.expTimeout = 1'b0; e.name = "t5 ptr0";
    step(e);

    // Test 6: conflict counter saturation
    @(negedge Clock);
    iReqValid = 4'b0000;
    force dut.conflictQ = 16'hFFFD;
    #1;
    release dut.conflictQ;
    expConf = 16'hFFFD;
    e.valid = 4'b0110; e.lock = '0; e.expLocked = 1'b0;
    e.expOwner = '0; e.expTimeout = 1'b0; e.name = "t6 sat";
    e.expReady = 4'b0010; step(e);
    e.expReady = 4'b0100; step(e);
    e.expReady = 4'b0010; step(e);
    e.expReady = 4'b0100; step(e);
    chk("t6 hold FFFF", 32'(oConflictCount), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
